alu_exec_unit: RTL and testbench

Execute-stage ALU fed directly by the ALU decoder's 4-bit control code and the register/immediate operand muxes. Accepts one operation per valid/ready handshake, computes the result and branch zero flag, and holds them in an output register until the downstream stage (memory/writeback or branch logic) accepts them. Shifts run iteratively, one bit per cycle, unless the fast-shift build option is enabled.

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu_shift_iter.sv | 55 +++++
 rtl/alu_exec_unit.sv | 106 ++++++++++
 tb/tb_alu_exec_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, FSM states and the single-cycle result/flag functions.
// Also used by the ALU decoder, so the control code values must not change.
package alu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000,
      ALU_SUB   = 4'b0001,
      ALU_AND   = 4'b0010,
      ALU_OR    = 4'b0011,
      ALU_XOR   = 4'b0100,
      ALU_SLL   = 4'b0101,
      ALU_SRL   = 4'b0110,
      ALU_SLT   = 4'b0111,
      ALU_SLTU  = 4'b1000,
      ALU_SRA   = 4'b1001,
      ALU_SUBNZ = 4'b1010,
      ALU_SLTNZ = 4'b1011,
      ALU_LUI   = 4'b1111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift(alu_ctrl_e op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

   // Codes not listed in the enum fall into the default arm and behave as ADD.
   function automatic logic [XLEN-1:0] alu_calc(alu_ctrl_e op, logic [XLEN-1:0] a,
                                                logic [XLEN-1:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         ALU_SUB, ALU_SUBNZ: return a - b;
         ALU_AND:            return a & b;
         ALU_OR:             return a | b;
         ALU_XOR:            return a ^ b;
         ALU_SLL:            return a << sh;
         ALU_SRL:            return a >> sh;
         ALU_SLT, ALU_SLTNZ: return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU:           return {{(XLEN-1){1'b0}}, a < b};
         ALU_SRA:            return $signed(a) >>> sh;
         ALU_LUI:            return b << 12;
         default:            return a + b;
      endcase
   endfunction

   // BNE/BGE reuse SUB/SLT with the sense of the branch flag flipped.
   function automatic logic alu_zero(alu_ctrl_e op, logic [XLEN-1:0] res);
      return (res == '0) ^ ((op == ALU_SUBNZ) || (op == ALU_SLTNZ));
   endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: one bit per cycle for SLL/SRL/SRA, counting the shift amount down.
// done is asserted in the cycle whose step yields the final value on result.
module alu_shift_iter
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            start,
   input  alu_ctrl_e       op,
   input  logic [XLEN-1:0] a,
   input  logic [4:0]      shamt,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   logic [XLEN-1:0] work_q;
   logic [4:0]      cnt_q;
   alu_ctrl_e       op_q;
   logic            busy_q;
   logic [XLEN-1:0] step;

   always_comb begin
      case (op_q)
         ALU_SRL: step = {1'b0, work_q[XLEN-1:1]};
         ALU_SRA: step = {work_q[XLEN-1], work_q[XLEN-1:1]};
         default: step = {work_q[XLEN-2:0], 1'b0};
      endcase
   end

   assign busy   = busy_q;
   assign done   = busy_q && (cnt_q == 5'd1);
   assign result = step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q <= '0;
         cnt_q  <= '0;
         op_q   <= ALU_SLL;
         busy_q <= 1'b0;
      end else if (flush) begin
         busy_q <= 1'b0;
      end else if (start) begin
         work_q <= a;
         cnt_q  <= shamt;
         op_q   <= op;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         work_q <= step;
         cnt_q  <= cnt_q - 5'd1;
         if (cnt_q == 5'd1) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and a held output register.
// Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts; otherwise shifts iterate one bit per cycle.
module alu_exec_unit
   import alu_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [3:0]      alu_control_i,
   input  logic [XLEN-1:0] src_a_i,
   input  logic [XLEN-1:0] src_b_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            zero_o
);
   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic            hs;
   alu_ctrl_e       ctrl;
   logic [XLEN-1:0] calc;

   assign ctrl        = alu_ctrl_e'(alu_control_i);
   assign calc        = alu_calc(ctrl, src_a_i, src_b_i);
   assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
   assign hs          = in_valid_i && in_ready_o && !flush_i;
   assign out_valid_o = (state_q == S_DONE);
   assign result_o    = result_q;
   assign zero_o      = zero_q;

`ifndef ALU_FAST_SHIFT_EN
   logic            sh_start, sh_busy, sh_done;
   logic [XLEN-1:0] sh_result;

   alu_shift_iter u_shift (
      .clk    (clk_i),
      .rst_n  (rst_n_i),
      .flush  (flush_i),
      .start  (sh_start),
      .op     (ctrl),
      .a      (src_a_i),
      .shamt  (src_b_i[4:0]),
      .busy   (sh_busy),
      .done   (sh_done),
      .result (sh_result)
   );
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
`ifndef ALU_FAST_SHIFT_EN
      sh_start = 1'b0;
`endif
      case (state_q)
         S_SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
            if (sh_done) begin
               state_d  = S_DONE;
               result_d = sh_result;
               zero_d   = (sh_result == '0);
            end else if (!sh_busy) begin
               state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: begin
            if ((state_q == S_DONE) && out_ready_i) state_d = S_IDLE;
            if (hs) begin
               state_d  = S_DONE;
               result_d = calc;
               zero_d   = alu_zero(ctrl, calc);
`ifndef ALU_FAST_SHIFT_EN
               // Zero-length shifts skip the iterator and complete like any other op.
               if (is_shift(ctrl) && (src_b_i[4:0] != 5'd0)) begin
                  sh_start = 1'b1;
                  state_d  = S_SHIFT;
                  result_d = result_q;
                  zero_d   = zero_q;
               end
`endif
            end
         end
      endcase
      if (flush_i) state_d = S_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops vs. an arithmetic model.
module tb_alu_exec_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic [31:0] src_a, src_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_exec_unit dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .flush_i       (flush),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .alu_control_i (alu_control),
      .src_a_i       (src_a),
      .src_b_i       (src_b),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .result_o      (result),
      .zero_o        (zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic is_sh(input logic [3:0] c);
      return (c == 4'd5) || (c == 4'd6) || (c == 4'd9);
   endfunction

   // Reference: direct arithmetic on the operands, no bit-serial behaviour.
   function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic z);
      int          sa, sb;
      int unsigned sh;
      logic [31:0] pw;
      sa = a; sb = b; sh = b % 32; pw = 32'd1 << sh;
      case (c)
         4'd1, 4'd10: r = a - b;
         4'd2:        r = a & b;
         4'd3:        r = a | b;
         4'd4:        r = a ^ b;
         4'd5:        r = a * pw;
         4'd6:        r = a / pw;
         4'd7, 4'd11: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd8:        r = (a < b) ? 32'd1 : 32'd0;
         4'd9:        r = sa >>> sh;
         4'd15:       r = b * 32'd4096;
         default:     r = a + b;
      endcase
      z = (r == 0) ^ ((c == 4'd10) || (c == 4'd11));
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Called #1 after a posedge with the unit idle; leaves it idle again.
   task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] er;
      logic        ez;
      int          lat, exp_lat;
      model(c, a, b, er, ez);
      exp_lat = (is_sh(c) && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 : 1;
      alu_control = c; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
      chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0; src_a = $urandom; src_b = $urandom;
      lat = 1;
      while (!out_valid && lat < 40) begin
         chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
         tick();
         lat++;
      end
      chk("latency", lat, exp_lat);
      for (int i = 0; i < hold; i++) begin
         chk("hold_result", result, er);
         chk("hold_zero", {31'b0, zero}, {31'b0, ez});
         chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
         tick();
         chk("hold_valid", {31'b0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      chk("result", result, er);
      chk("zero", {31'b0, zero}, {31'b0, ez});
      tick();
      out_ready = 1'b0;
      chk("valid_drop", {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_control = '0; src_a = '0; src_b = '0;
      repeat (2) tick();
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd0);
      rst_n = 1'b1;
      tick();

      // ADD then SUB back-to-back with downstream always ready
      out_ready = 1'b1; alu_control = 4'd0; src_a = 5; src_b = 7; in_valid = 1'b1;
      tick();
      alu_control = 4'd1; src_a = 7; src_b = 7;
      chk("b2b_valid1", {31'b0, out_valid}, 32'd1);
      chk("b2b_res1", result, 32'd12);
      chk("b2b_zero1", {31'b0, zero}, 32'd0);
      chk("b2b_ready1", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("b2b_valid2", {31'b0, out_valid}, 32'd1);
      chk("b2b_res2", result, 32'd0);
      chk("b2b_zero2", {31'b0, zero}, 32'd1);
      tick();
      out_ready = 1'b0;
      chk("b2b_idle", {31'b0, out_valid}, 32'd0);

      do_op(4'd10, 32'd3, 32'd3, 0);
      do_op(4'd11, 32'hFFFF_FFFF, 32'd2, 0);
      do_op(4'd9, 32'h8000_0000, 32'd4, 0);
      do_op(4'd9, 32'h8000_0000, 32'd0, 0);
      do_op(4'd6, 32'hFFFF_FFFF, 32'd31, 1);
      do_op(4'd15, 32'd0, 32'h000A_BCDE, 3);
      do_op(4'd12, 32'd10, 32'd20, 0);

      // Reset in the middle of a shift discards it
      alu_control = 4'd5; src_a = 32'd1; src_b = 32'd20; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      chk("shift_busy", {31'b0, in_ready}, 32'd0);
      rst_n = 1'b0;
      tick();
      chk("midrst_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_ready", {31'b0, in_ready}, 32'd1);
      chk("midrst_result", result, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         if (out_valid) chk("midrst_ghost", {31'b0, out_valid}, 32'd0);
         tick();
      end
      chk("midrst_quiet", {31'b0, out_valid}, 32'd0);

      // Flush during a shift, with a competing handshake in the flush cycle
      alu_control = 4'd5; src_a = 32'd3; src_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      flush = 1'b1;
      tick();
      chk("flush_idle", {31'b0, in_ready}, 32'd1);
      alu_control = 4'd0; src_a = 1; src_b = 1; in_valid = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (out_valid) chk("flush_ghost", {31'b0, out_valid}, 32'd0);
         tick();
      end
      chk("flush_quiet", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b0;
      do_op(4'd0, 32'd100, 32'd23, 0);

      // Flush while a result is held under back-pressure
      alu_control = 4'd3; src_a = 32'hF0; src_b = 32'h0F; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("held_valid", {31'b0, out_valid}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_done", {31'b0, out_valid}, 32'd0);

      for (int n = 0; n < 150; n++)
         do_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 2));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
